// File: rtl/mpu_memory_loader_if.sv
// rtl/mpu_memory_loader_if.sv - byte stream in and memory write port out of the MPU loader
interface mpu_memory_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  // master: host stream source and memory sink; slave: the loader itself
  modport master (
    output s_data, s_valid, s_last,
    input  s_ready,
    input  we, w_addr, w_data
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready,
    output we, w_addr, w_data
  );
endinterface

// File: rtl/mpu_memory_loader.sv
// rtl/mpu_memory_loader.sv - packs a byte stream little-endian into words written at auto-incrementing addresses
module mpu_memory_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  mpu_memory_loader_if.slave    mem,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-1:0] assembly;
  logic [DATA_WIDTH-1:0] merged;
  logic                  last_seen;
  logic                  xfer;

  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    merged     = assembly | ({{(DATA_WIDTH-8){1'b0}}, mem.s_data} << {byte_idx, 3'b000});
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (mem.s_valid && mem.s_ready) begin
          xfer = 1'b1;
          if (byte_idx == 2'd3 || mem.s_last) state_next = ST_WRITE;
        end
      end
      ST_WRITE: state_next = last_seen ? ST_DONE : ST_LOAD;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Handshake/status outputs are registered from the next state so they line up with it.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      mem.s_ready <= 1'b0;
      mem.we      <= 1'b0;
      mem.w_addr  <= '0;
      mem.w_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      word_count  <= '0;
      overflow    <= 1'b0;
      ptr         <= '0;
      byte_idx    <= 2'd0;
      assembly    <= '0;
      last_seen   <= 1'b0;
    end else begin
      mem.s_ready <= (state_next == ST_LOAD);
      mem.we      <= (state_next == ST_WRITE);
      busy        <= (state_next != ST_IDLE);
      done        <= (state_next == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr        <= base_addr;
            byte_idx   <= 2'd0;
            assembly   <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            last_seen  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            assembly  <= merged;
            byte_idx  <= byte_idx + 2'd1;
            last_seen <= mem.s_last;
            if (state_next == ST_WRITE) begin
              mem.w_addr <= ptr;
              mem.w_data <= merged;
            end
          end
        end
        ST_WRITE: begin
          ptr        <= ptr + ADDR_ONE;
          word_count <= word_count + ADDR_ONE;
          byte_idx   <= 2'd0;
          assembly   <= '0;
          if (&ptr) overflow <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_memory_loader.sv
// tb/tb_mpu_memory_loader.sv - randomized self-checking bench for mpu_memory_loader
module tb_mpu_memory_loader;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [15:0] base_addr;
  logic        busy;
  logic        done;
  logic [15:0] word_count;
  logic        overflow;

  mpu_memory_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) mem ();

  mpu_memory_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .base_addr  (base_addr),
    .mem        (mem.slave),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .overflow   (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  bytes[$];
  int          cyc = 0;
  int          we_total = 0;
  int          last_we_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (mem.we) begin
      got_addr.push_back(mem.w_addr);
      got_data.push_back(mem.w_data);
      we_total++;
      last_we_cyc = cyc;
      check("ready_low_in_write", mem.s_ready, 0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("ready_low_in_done", mem.s_ready, 0);
      check("busy_in_done", busy, 1);
    end
  end

  // Reference: word k takes bytes 4k..4k+3 little-endian, lands at base+k mod 2^16.
  task automatic run_load(input logic [15:0] base, input int gap_pct, input bit poke);
    int          n;
    int          nw;
    int          idx;
    int          cycles;
    bit          took;
    bit          seen;
    bit          exp_ovf;
    logic [31:0] word;
    logic [15:0] addr;

    n = bytes.size();
    nw = (n + 3) / 4;
    exp_addr.delete();
    exp_data.delete();
    exp_ovf = 1'b0;
    for (int k = 0; k < nw; k++) begin
      word = 32'h0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < n) word = word | (32'(bytes[4 * k + j]) << (8 * j));
      addr = base + 16'(k);
      exp_addr.push_back(addr);
      exp_data.push_back(word);
      if (addr == 16'hFFFF) exp_ovf = 1'b1;
    end
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;

    @(posedge sys_clk); #1;
    start = 1'b1;
    base_addr = base;
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ready_after_start", mem.s_ready, 1);
    check("count_cleared", word_count, 0);

    idx = 0;
    cycles = 0;
    while (idx < n && cycles < 2000) begin
      mem.s_valid = ($urandom_range(99) >= gap_pct);
      mem.s_data  = bytes[idx];
      mem.s_last  = (idx == n - 1);
      if (poke && idx == 2) begin
        start = 1'b1;
        base_addr = 16'h0300;
      end else begin
        start = 1'b0;
      end
      took = mem.s_valid && mem.s_ready;
      @(posedge sys_clk); #1;
      if (took) idx++;
      cycles++;
    end
    check("stream_consumed", idx, n);
    mem.s_valid = 1'b0;
    mem.s_last  = 1'b0;
    start = 1'b0;

    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge sys_clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      start = 1'b1;
      base_addr = 16'h0300;
      @(posedge sys_clk); #1;
      start = 1'b0;
      @(negedge sys_clk);
      check("start_in_done_ignored", busy, 0);
    end

    check("write_count", got_addr.size(), nw);
    for (int k = 0; k < nw && k < got_addr.size(); k++) begin
      check("w_addr", got_addr[k], exp_addr[k]);
      check("w_data", got_data[k], exp_data[k]);
    end
    check("done_after_last_we", done_cyc, last_we_cyc + 1);
    check("done_single_pulse", done_cnt, 1);
    check("word_count", word_count, nw);
    check("overflow", overflow, exp_ovf);
    check("we_idle", mem.we, 0);
    if (nw > 0) begin
      check("w_addr_held", mem.w_addr, exp_addr[nw - 1]);
      check("w_data_held", mem.w_data, exp_data[nw - 1]);
    end
  endtask

  task automatic set_test1_bytes();
    bytes.delete();
    for (int i = 0; i < 8; i++) bytes.push_back(8'(8'h11 * (i + 1)));
  endtask

  int we_before;
  int nb;

  initial begin
    sys_rst = 1'b0;
    start = 1'b0;
    base_addr = 16'h0;
    mem.s_data = 8'h0;
    mem.s_valid = 1'b0;
    mem.s_last = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_ready", mem.s_ready, 0);
    check("rst_we", mem.we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", word_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_w_addr", mem.w_addr, 0);
    check("rst_w_data", mem.w_data, 0);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    set_test1_bytes();
    run_load(16'h0010, 0, 1'b0);

    bytes.delete();
    bytes.push_back(8'hAA);
    bytes.push_back(8'hBB);
    bytes.push_back(8'hCC);
    run_load(16'h0100, 0, 1'b0);

    set_test1_bytes();
    run_load(16'h0010, 50, 1'b0);

    bytes.delete();
    for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
    run_load(16'hFFFF, 0, 1'b0);
    repeat (3) @(negedge sys_clk);
    check("overflow_held", overflow, 1);
    check("count_held", word_count, 2);

    // Abort mid-load with an asynchronous reset.
    @(posedge sys_clk); #1;
    start = 1'b1;
    base_addr = 16'h0020;
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("overflow_cleared_by_start", overflow, 0);
    we_before = we_total;
    mem.s_valid = 1'b1;
    mem.s_data = 8'h5A;
    @(posedge sys_clk); #1;
    mem.s_data = 8'hA5;
    @(posedge sys_clk); #1;
    mem.s_valid = 1'b0;
    #2 sys_rst = 1'b0;
    #1;
    check("abort_ready", mem.s_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_count", word_count, 0);
    check("abort_w_data", mem.w_data, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("abort_no_we", we_total, we_before);
    check("abort_no_done", done, 0);

    set_test1_bytes();
    run_load(16'h0010, 0, 1'b0);

    set_test1_bytes();
    run_load(16'h0010, 30, 1'b1);

    for (int t = 0; t < 20; t++) begin
      nb = $urandom_range(12, 1);
      bytes.delete();
      for (int i = 0; i < nb; i++) bytes.push_back(8'($urandom));
      run_load((t % 4 == 0) ? 16'(16'hFFFD + $urandom_range(2)) : 16'($urandom),
               $urandom_range(60), t[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mpu_memory_loader.md
Name: mpu_memory_loader

Overview:
- Write-side producer for the MPU program/data memory.
- Accepts a byte stream from the host-side control path and packs it little-endian into 32-bit words.
- Drives the memory write port (we/w_addr/w_data) with an auto-incrementing address from a programmable base.
- Reports completion, number of words written and address wrap-around.

Parameters:
ADDR_WIDTH, 16, width of w_addr, base_addr and word_count
DATA_WIDTH, 32, width of w_data; fixed at 4 bytes, other values unsupported

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request to begin a load; honoured only in IDLE
base_addr  input  ADDR_WIDTH  first word address, sampled when start is honoured
s_data  input  8  stream byte
s_valid  input  1  s_data/s_last valid
s_last  input  1  current byte is the final byte of the load
s_ready  output  1  loader accepts a byte this cycle
we  output  1  memory write enable, one cycle per word
w_addr  output  ADDR_WIDTH  memory write address
w_data  output  DATA_WIDTH  memory write data
busy  output  1  high from honoured start until done pulse inclusive
done  output  1  one-cycle pulse after the final word is written
word_count  output  ADDR_WIDTH  words written since last honoured start
overflow  output  1  sticky: address wrapped past all-ones during this load

Behaviour:
- Reset (sys_rst low, asynchronous): state IDLE; all outputs 0; internal pointer, byte index and assembly register cleared. Deassertion is synchronised by the top level.
- All outputs are registered. s_ready is a registered function of state.
- Byte transfer occurs on a clock edge where s_valid && s_ready are both high.
- IDLE:
  - s_ready=0, busy=0.
  - start=1: ptr<=base_addr, byte_idx<=0, assembly<=0, word_count<=0, overflow<=0, -> LOAD.
- LOAD:
  - s_ready=1, busy=1.
  - Each transfer writes s_data into lane byte_idx (first byte -> bits 7:0, fourth -> bits 31:24).
  - byte_idx increments after each transfer.
  - Transfer with byte_idx==3 or s_last=1: -> WRITE. Unfilled lanes remain 0; last flag latched.
  - s_valid low: state and contents hold indefinitely.
- WRITE (exactly one cycle):
  - we=1, w_addr=ptr, w_data=assembly; s_ready=0.
  - On exit: ptr<=ptr+1 modulo 2^ADDR_WIDTH, word_count<=word_count+1, byte_idx<=0, assembly<=0.
  - If ptr was all-ones: overflow<=1.
  - Latched last -> DONE, else -> LOAD.
- DONE (one cycle): done=1, busy=1, s_ready=0; -> IDLE.
- Latency and throughput:
  - Fourth byte (or s_last byte) accepted at edge N; we high in cycle N+1.
  - Peak throughput: 4 bytes per 5 cycles.
  - done follows the final we by exactly one cycle.
- After a write, w_addr and w_data hold their last values; we returns to 0.
- Held values:
  - word_count and overflow hold after DONE until the next honoured start.
  - word_count wraps modulo 2^ADDR_WIDTH.
- start outside IDLE is ignored, including the DONE cycle.
- s_valid outside LOAD is ignored; no byte is consumed.
- s_last on byte_idx==3: the word is written once and the load finishes; no extra empty word.
- Reset mid-operation aborts the load immediately. A partially assembled word is never written, and no done pulse occurs.

Test Plan:
1. Two full words: start, base_addr=0x0010; bytes 11 22 33 44 55 66 77 88, s_last on 88.
   -> we at 0x0010 data 0x44332211, then 0x0011 data 0x88776655; done one cycle after second we; word_count=2; overflow=0.
2. Partial word: base 0x0100; bytes AA BB CC, s_last on CC.
   -> single we at 0x0100 data 0x00CCBBAA; word_count=1; done pulses.
3. Flow control: same stream as 1 with s_valid low on alternate cycles.
   -> identical writes and data; s_ready=0 during each WRITE and DONE cycle; no byte lost or duplicated.
4. Wrap: base 0xFFFF; 8 bytes, last on eighth.
   -> writes at 0xFFFF then 0x0000; overflow=1 after first write and held after done; a new start clears it.
5. Reset mid-load: start, base 0x0020; accept 2 bytes; pull sys_rst low.
   -> all outputs 0 immediately; no we ever issued. After release, the load of test 1 completes correctly.
6. Start while busy: pulse start with base 0x0300 during LOAD of test 1.
   -> ignored; writes still land at 0x0010/0x0011.
